bus_timer: RTL

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_if.sv | 30 +++
 rtl/bus_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_if.sv
// System-bus follower/leader bundle used to reach the timer registers.
interface bus_timer_if;
  logic [31:0] addr;
  logic        read_req;
  logic        write_req;
  logic [3:0]  byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport follower (
    input  addr,
    input  read_req,
    input  write_req,
    input  byte_enable,
    input  write_data,
    output read_data,
    output read_data_valid
  );

  modport leader (
    output addr,
    output read_req,
    output write_req,
    output byte_enable,
    output write_data,
    input  read_data,
    input  read_data_valid
  );
endinterface

// File: rtl/bus_timer.sv
// Prescaled 32-bit timer with compare match, optional auto-reload and a level
// interrupt; registers CTRL/PRESCALE/COUNT/COMPARE are accessed over the system bus.
module bus_timer #(
  parameter int unsigned PrescaleWidth = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  bus_timer_if.follower   bus,
  output logic            irq
);

  localparam logic [PrescaleWidth-1:0] PcntZero = {PrescaleWidth{1'b0}};
  localparam logic [PrescaleWidth-1:0] PcntOne  = PrescaleWidth'(32'd1);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic                     en_q, en_d;
  logic                     irq_en_q, irq_en_d;
  logic                     reload_q, reload_d;
  logic                     match_q, match_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;
  logic [31:0]              count_q, count_d;
  logic [31:0]              compare_q, compare_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;
  logic                     irq_q, irq_d;

  logic                     tick_s;
  logic                     match_set_s;
  logic                     wr_ctrl_s, wr_pre_s, wr_count_s, wr_cmp_s;
  logic [31:0]              prescale_ext_s;
  logic [31:0]              prescale_wr_s;
  logic                     addr_unused_s;

  assign addr_unused_s = ^{bus.addr[31:4], bus.addr[1:0]};

  // Next-state: prescaler, counter/match, register writes and read response.
  always_comb begin
    en_d           = en_q;
    irq_en_d       = irq_en_q;
    reload_d       = reload_q;
    match_d        = match_q;
    prescale_d     = prescale_q;
    pcnt_d         = pcnt_q;
    count_d        = count_q;
    compare_d      = compare_q;
    rdata_d        = 32'd0;
    rvalid_d       = 1'b0;
    match_set_s    = 1'b0;
    prescale_ext_s = 32'(prescale_q);
    prescale_wr_s  = merge_lanes(prescale_ext_s, bus.write_data, bus.byte_enable);

    wr_ctrl_s  = bus.write_req && (bus.addr[3:2] == 2'd0);
    wr_pre_s   = bus.write_req && (bus.addr[3:2] == 2'd1);
    wr_count_s = bus.write_req && (bus.addr[3:2] == 2'd2);
    wr_cmp_s   = bus.write_req && (bus.addr[3:2] == 2'd3);

    tick_s = en_q && (pcnt_q == prescale_q);

    if (en_q) begin
      if (tick_s) begin
        pcnt_d = PcntZero;
      end else begin
        pcnt_d = pcnt_q + PcntOne;
      end
    end else begin
      pcnt_d = pcnt_q;
    end

    if (tick_s) begin
      if (count_q == compare_q) begin
        match_set_s = 1'b1;
        count_d     = reload_q ? 32'd0 : count_q + 32'd1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end else begin
      count_d = count_q;
    end

    if (wr_ctrl_s) begin
      if (bus.byte_enable[0]) begin
        {reload_d, irq_en_d, en_d} = bus.write_data[2:0];
      end else begin
        {reload_d, irq_en_d, en_d} = {reload_q, irq_en_q, en_q};
      end
      if (bus.byte_enable[1] && bus.write_data[8]) begin
        match_d = 1'b0;
      end else begin
        match_d = match_q;
      end
    end else begin
      match_d = match_q;
    end
    // A match raised by this tick must survive a simultaneous W1C.
    if (match_set_s) begin
      match_d = 1'b1;
    end else begin
      match_d = match_d;
    end

    if (wr_pre_s) begin
      prescale_d = prescale_wr_s[PrescaleWidth-1:0];
      pcnt_d     = PcntZero;
    end else begin
      prescale_d = prescale_q;
    end

    if (wr_count_s) begin
      count_d = merge_lanes(count_q, bus.write_data, bus.byte_enable);
      pcnt_d  = PcntZero;
    end else begin
      count_d = count_d;
    end

    if (wr_cmp_s) begin
      compare_d = merge_lanes(compare_q, bus.write_data, bus.byte_enable);
    end else begin
      compare_d = compare_q;
    end

    if (bus.read_req) begin
      rvalid_d = 1'b1;
      case (bus.addr[3:2])
        2'd0:    rdata_d = {23'd0, match_q, 5'd0, reload_q, irq_en_q, en_q};
        2'd1:    rdata_d = prescale_ext_s;
        2'd2:    rdata_d = count_q;
        2'd3:    rdata_d = compare_q;
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rvalid_d = 1'b0;
      rdata_d  = 32'd0;
    end

    irq_d = match_d & irq_en_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      reload_q   <= 1'b0;
      match_q    <= 1'b0;
      prescale_q <= PcntZero;
      pcnt_q     <= PcntZero;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      reload_q   <= reload_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.read_data       = rdata_q;
  assign bus.read_data_valid = rvalid_q;
  assign irq                 = irq_q;

endmodule
